// File: rtl/fwd_pipe_unit.sv
// Post-execute pipeline (MEM..WB) with operand forwarding and load-use hazard detection.
// Stage 0 is the youngest entry and stage DEPTH-1 drives the register-file write port.
module fwd_pipe_unit #(
    parameter int unsigned N        = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LD_STAGE = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          in_wr_en,
    input  logic          in_is_load,
    input  logic [AW-1:0] in_rw,
    input  logic [N-1:0]  in_data,
    input  logic [N-1:0]  ld_data,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    input  logic [N-1:0]  rda_rf,
    input  logic [N-1:0]  rdb_rf,
    output logic [N-1:0]  operand_a,
    output logic [N-1:0]  operand_b,
    output logic          hazard,
    output logic          wb_en,
    output logic [AW-1:0] wb_rw,
    output logic [N-1:0]  wb_data
);

    typedef struct packed {
        logic          valid;
        logic          wr_en;
        logic          is_load;
        logic [AW-1:0] rw;
        logic [N-1:0]  data;
    } entry_t;

    entry_t stage_q [DEPTH];
    entry_t stage_d [DEPTH];
    entry_t in_entry;

    logic found_a;
    logic found_b;
    logic haz_a;
    logic haz_b;

    // Next-state: shift by one stage, with memory data merged into the load-return stage.
    always_comb begin
        in_entry = '0;
        if (in_valid && !flush) begin
            in_entry.valid   = 1'b1;
            in_entry.wr_en   = in_wr_en;
            in_entry.is_load = in_is_load;
            in_entry.rw      = in_rw;
            in_entry.data    = in_data;
        end

        stage_d[0] = in_entry;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
        end

        if (stage_d[LD_STAGE].valid && stage_d[LD_STAGE].is_load) begin
            stage_d[LD_STAGE].data = ld_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stage_q <= '{default: '0};
        end else if (!stall) begin
            stage_q <= stage_d;
        end
    end

    // Youngest matching stage wins; a load still ahead of LD_STAGE has no data yet.
    always_comb begin
        operand_a = rda_rf;
        operand_b = rdb_rf;
        found_a   = 1'b0;
        found_b   = 1'b0;
        haz_a     = 1'b0;
        haz_b     = 1'b0;

        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!found_a && stage_q[k].valid && stage_q[k].wr_en &&
                stage_q[k].rw == ra && ra != '0) begin
                found_a   = 1'b1;
                operand_a = stage_q[k].data;
                haz_a     = stage_q[k].is_load && (k < LD_STAGE);
            end
            if (!found_b && stage_q[k].valid && stage_q[k].wr_en &&
                stage_q[k].rw == rb && rb != '0) begin
                found_b   = 1'b1;
                operand_b = stage_q[k].data;
                haz_b     = stage_q[k].is_load && (k < LD_STAGE);
            end
        end

        hazard = haz_a | haz_b;
    end

    assign wb_en   = stage_q[DEPTH-1].valid & stage_q[DEPTH-1].wr_en;
    assign wb_rw   = stage_q[DEPTH-1].rw;
    assign wb_data = stage_q[DEPTH-1].data;

endmodule
